spi_slave_regfile: RTL
======================

// Module: spi_slave_regfile
// PURPOSE
//   SPI mode-0 slave with an internal register file. It is the downstream peer of
//   apb_spi_master and decodes that block's CMD / ADDR / data frames.
//   All SPI inputs are oversampled in the pclk_i domain; no logic runs on the spi_clk_i edge.
//   Used as the on-chip loopback target and as the bus-functional SPI device in system sims.
// PARAMETERS
//   ADDR_W    4     register-file address width; depth = 2**ADDR_W
//   DATA_W    16    register width = data bits per word on the wire
//   CMD_WR    8'h0A write command code
//   CMD_RD    8'h0B read command code
// PORTS
//   pclk_i       in   1       system clock; the only clock
//   rst_n_i      in   1       asynchronous active-low reset
//   spi_clk_i    in   1       SPI clock from the master; idle low
//   spi_cs_n_i   in   1       chip select, active low
//   spi_sdi_i    in   1       MOSI (master spi_sdo_o)
//   spi_sdo_o    out  1       MISO (master spi_sdi_i)
//   spi_sdo_oe_o out  1       MISO output enable
//   wr_valid_o   out  1       1-cycle pulse when a register is written
//   wr_addr_o    out  ADDR_W  address of the write; valid with wr_valid_o
//   wr_data_o    out  DATA_W  data of the write; valid with wr_valid_o
//   cmd_err_o    out  1       1-cycle pulse when an unknown command is received
//   dbg_addr_i   in   ADDR_W  debug read address
//   dbg_rdata_o  out  DATA_W  mem[dbg_addr_i], combinational
// BEHAVIOUR
//   Reset (async, rst_n_i=0):
//     - all outputs 0; every mem entry cleared to 0
//     - synchronisers load idle values: clk=0, cs_n=1
//     - FSM goes to IDLE
//   Sync: spi_clk_i, spi_cs_n_i and spi_sdi_i each pass through 2 flops; edges are
//     detected on the 2nd/3rd stage.
//     - A rising or falling edge is acted on 3 pclk after the pin edge.
//     - Required: spi_clk high time >= 4 pclk and low time >= 4 pclk.
//   Frame format: MSB first on every field.
//     - CMD: 8 bits
//     - ADDR: 8 bits; the low ADDR_W bits are used
//     - then N words of DATA_W bits
//     - MOSI is sampled on the detected rising edge; MISO changes on the detected falling edge.
//   FSM states and transitions:
//     - IDLE -> CMD when cs_n goes low. Bit counter cleared; sdo=0, oe=0.
//     - CMD: after 8 bits, code==CMD_WR -> ADDR(wr); code==CMD_RD -> ADDR(rd);
//       any other code -> IGNORE, with cmd_err_o pulsing for 1 cycle.
//     - ADDR: after 8 bits, load addr and go to WDATA or RDATA.
//       On read, the shift register is loaded from mem[addr] on the same pclk.
//     - WDATA: after DATA_W bits, mem[addr] <= word on the next pclk, wr_valid_o pulses with
//       addr/data, then addr++.
//     - RDATA: oe=1.
//       - The first falling edge after the last ADDR bit drives the MSB.
//       - Each later falling edge shifts out the next bit.
//       - On the rising edge that completes a word, addr++ and the shift register reloads from
//         mem[addr+1]; the next falling edge drives its MSB.
//     - IGNORE: consumes bits; sdo=0, oe=0; no writes.
//   addr++ wraps modulo 2**ADDR_W.
//   cs_n synced high in any state -> IDLE next pclk:
//     - a partial write word is discarded (no wr_valid_o)
//     - sdo=0 and oe=0
//     - the bit counter is reset
//   spi_clk edges while cs_n is high are ignored.
//   If cs_n rises and a clock edge arrive in the same pclk, cs_n wins.
//   Reset mid-frame: immediate return to reset state; mem is cleared.
//   A write pulse and a debug read of the same address in the same cycle:
//     dbg_rdata_o shows the old value until the next pclk.
// TESTING
//   1. Frame 0x0A, 0x0B, 0xA001 -> wr_valid_o x1 with addr=0xB, data=0xA001; dbg_rdata_o[0xB]=0xA001.
//   2. After test 1, frame 0x0B, 0x0B, 16 clocks -> MISO sampled on rising edges =
//      0xA001 MSB-first; oe=1 only during the data phase.
//   3. Write burst addr=0xF, data 0x1111, 0x2222 -> mem[0xF]=0x1111, mem[0x0]=0x2222 (wrap);
//      read burst from 0xF returns the same two words.
//   4. Write frame with cs_n raised after 10 data bits -> no wr_valid_o and mem unchanged;
//      the next full frame is written correctly.
//   5. CMD 0x55 followed by 24 clocks -> cmd_err_o pulse x1, sdo=0 and oe=0, no writes.
//   6. rst_n_i asserted mid-RDATA -> sdo/oe/pulses 0 immediately, all mem=0;
//      after release a 0x0A frame writes normally.
//   All tests run with spi_clk half-period = 4 pclk (minimum) and with 8 pclk.

Source files
------------

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave decoding CMD/ADDR/DATA frames into a register file, oversampled on pclk_i.
// Latency: pin edges acted on 3 pclk later; no backpressure (the SPI master paces every transfer).
module spi_slave_regfile #(
  parameter int         ADDR_W = 4,
  parameter int         DATA_W = 16,
  parameter logic [7:0] CMD_WR = 8'h0A,
  parameter logic [7:0] CMD_RD = 8'h0B
) (
  input  logic              pclk_i,
  input  logic              rst_n_i,
  input  logic              spi_clk_i,
  input  logic              spi_cs_n_i,
  input  logic              spi_sdi_i,
  output logic              spi_sdo_o,
  output logic              spi_sdo_oe_o,
  output logic              wr_valid_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              cmd_err_o,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_rdata_o
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RDATA, S_IGNORE} state_t;

  state_t              state, state_nx;
  logic [2:0]          clk_sync;
  logic [1:0]          cs_sync;
  logic [1:0]          sdi_sync;
  logic [7:0]          bit_cnt;
  logic [DATA_W-1:0]   shift;
  logic [DATA_W-1:0]   shift_in;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   addr_inc;
  logic                is_rd;
  logic [DATA_W-1:0]   mem [2**ADDR_W];
  logic                cs_n_s, clk_rise, clk_fall, last_byte, last_word, code_ok;
  logic [7:0]          code;

  always_ff @(posedge pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      clk_sync <= 3'b000;
      cs_sync  <= 2'b11;
      sdi_sync <= 2'b00;
    end else begin
      clk_sync <= {clk_sync[1:0], spi_clk_i};
      cs_sync  <= {cs_sync[0], spi_cs_n_i};
      sdi_sync <= {sdi_sync[0], spi_sdi_i};
    end
  end

  // Clock edges only count while the synced chip select is low.
  assign cs_n_s    = cs_sync[1];
  assign clk_rise  = clk_sync[1] & ~clk_sync[2] & ~cs_n_s;
  assign clk_fall  = ~clk_sync[1] & clk_sync[2] & ~cs_n_s;
  assign shift_in  = {shift[DATA_W-2:0], sdi_sync[1]};
  assign code      = shift_in[7:0];
  assign code_ok   = (code == CMD_WR) || (code == CMD_RD);
  assign last_byte = (bit_cnt == 8'd7);
  assign last_word = (bit_cnt == 8'(DATA_W-1));
  assign addr_inc  = addr + 1'b1;
  assign dbg_rdata_o = mem[dbg_addr_i];

  always_ff @(posedge pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (cs_n_s) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nx = S_CMD;
        S_CMD:   if (clk_rise && last_byte) state_nx = code_ok ? S_ADDR : S_IGNORE;
        S_ADDR:  if (clk_rise && last_byte) state_nx = is_rd ? S_RDATA : S_WDATA;
        default: state_nx = state;
      endcase
    end
  end

  always_comb begin
    spi_sdo_oe_o = 1'b0;
    if (state == S_RDATA) spi_sdo_oe_o = 1'b1;
  end

  always_ff @(posedge pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bit_cnt    <= '0;
      shift      <= '0;
      addr       <= '0;
      is_rd      <= 1'b0;
      spi_sdo_o  <= 1'b0;
      wr_valid_o <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      cmd_err_o  <= 1'b0;
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
    end else begin
      wr_valid_o <= 1'b0;
      cmd_err_o  <= 1'b0;
      if (cs_n_s) begin
        bit_cnt   <= '0;
        spi_sdo_o <= 1'b0;
      end else begin
        case (state)
          S_CMD: if (clk_rise) begin
            shift   <= shift_in;
            bit_cnt <= last_byte ? 8'd0 : bit_cnt + 8'd1;
            if (last_byte) begin
              is_rd     <= (code == CMD_RD);
              cmd_err_o <= ~code_ok;
            end
          end
          S_ADDR: if (clk_rise) begin
            shift   <= shift_in;
            bit_cnt <= last_byte ? 8'd0 : bit_cnt + 8'd1;
            if (last_byte) begin
              addr <= shift_in[ADDR_W-1:0];
              if (is_rd) shift <= mem[shift_in[ADDR_W-1:0]];
            end
          end
          S_WDATA: if (clk_rise) begin
            shift   <= shift_in;
            bit_cnt <= last_word ? 8'd0 : bit_cnt + 8'd1;
            if (last_word) begin
              mem[addr]  <= shift_in;
              wr_valid_o <= 1'b1;
              wr_addr_o  <= addr;
              wr_data_o  <= shift_in;
              addr       <= addr_inc;
            end
          end
          // Reload on the completing rise so the next fall already drives the new MSB.
          S_RDATA: begin
            if (clk_rise) begin
              bit_cnt <= last_word ? 8'd0 : bit_cnt + 8'd1;
              if (last_word) begin
                addr  <= addr_inc;
                shift <= mem[addr_inc];
              end
            end else if (clk_fall) begin
              spi_sdo_o <= shift[DATA_W-1];
              shift     <= {shift[DATA_W-2:0], 1'b0};
            end
          end
          default: begin
            bit_cnt   <= '0;
            spi_sdo_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
